// File: rtl/demux4_1_stream.sv
// 1-to-4 stream steering unit: one input word per handshake is routed by in_sel
// into one of four independent 1-entry output channels, each with its own delivery counter.
module demux4_1_stream #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             a_valid,
  output logic             b_valid,
  output logic             c_valid,
  output logic             d_valid,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             c_ready,
  input  logic             d_ready,
  output logic [WIDTH-1:0] a_data,
  output logic [WIDTH-1:0] b_data,
  output logic [WIDTH-1:0] c_data,
  output logic [WIDTH-1:0] d_data,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt,
  output logic [CNT_W-1:0] c_cnt,
  output logic [CNT_W-1:0] d_cnt
);

  logic [3:0]       ready_s;
  logic [3:0]       load_s;
  logic [3:0]       deliver_s;
  logic [3:0]       valid_q;
  logic [3:0]       valid_d;
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [CNT_W-1:0] cnt_q  [4];
  logic [CNT_W-1:0] cnt_d  [4];

  assign ready_s = {d_ready, c_ready, b_ready, a_ready};

  // A full channel can still accept when its consumer drains it in the same cycle.
  assign in_ready = ~valid_q[in_sel] | ready_s[in_sel];

  // Per-channel next state: load, drain, hold, and delivery counting
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      load_s[i]    = in_valid & in_ready & (in_sel == 2'(i));
      deliver_s[i] = valid_q[i] & ready_s[i];
      valid_d[i]   = load_s[i] | (valid_q[i] & ~ready_s[i]);
      if (load_s[i]) begin
        data_d[i] = in_data;
      end else begin
        data_d[i] = data_q[i];
      end
      if (deliver_s[i]) begin
        cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Channel holding registers and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= {WIDTH{1'b0}};
        cnt_q[i]  <= {CNT_W{1'b0}};
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= data_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign a_valid = valid_q[0];
  assign b_valid = valid_q[1];
  assign c_valid = valid_q[2];
  assign d_valid = valid_q[3];
  assign a_data  = data_q[0];
  assign b_data  = data_q[1];
  assign c_data  = data_q[2];
  assign d_data  = data_q[3];
  assign a_cnt   = cnt_q[0];
  assign b_cnt   = cnt_q[1];
  assign c_cnt   = cnt_q[2];
  assign d_cnt   = cnt_q[3];

endmodule

// File: tb/tb_demux4_1_stream.sv
// Scoreboard bench for demux4_1_stream: directed test-plan sequences plus a
// randomized phase, checked against a per-channel queue model of the steering rules.
module tb_demux4_1_stream;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_sel = 2'd0;
  logic [WIDTH-1:0] in_data = 16'h0000;
  logic             a_valid, b_valid, c_valid, d_valid;
  logic             a_ready = 1'b1, b_ready = 1'b1, c_ready = 1'b1, d_ready = 1'b1;
  logic [WIDTH-1:0] a_data, b_data, c_data, d_data;
  logic [CNT_W-1:0] a_cnt, b_cnt, c_cnt, d_cnt;

  demux4_1_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
    .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready), .d_ready(d_ready),
    .a_data(a_data), .b_data(b_data), .c_data(c_data), .d_data(d_data),
    .a_cnt(a_cnt), .b_cnt(b_cnt), .c_cnt(c_cnt), .d_cnt(d_cnt)
  );

  always #5 clk = ~clk;

  logic [3:0]       act_v;
  logic [3:0]       rdy;
  logic [WIDTH-1:0] act_d [4];
  logic [CNT_W-1:0] act_c [4];
  assign act_v = {d_valid, c_valid, b_valid, a_valid};
  assign rdy   = {d_ready, c_ready, b_ready, a_ready};
  assign act_d[0] = a_data; assign act_d[1] = b_data;
  assign act_d[2] = c_data; assign act_d[3] = d_data;
  assign act_c[0] = a_cnt;  assign act_c[1] = b_cnt;
  assign act_c[2] = c_cnt;  assign act_c[3] = d_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: words accepted but not yet delivered, last word per channel, delivery counts
  logic [WIDTH-1:0] sbq [4][$];
  logic [WIDTH-1:0] last_data [4];
  logic [CNT_W-1:0] mcnt [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against the model every cycle, then advance the model by this cycle's transfers
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        sbq[i].delete();
        last_data[i] = 16'h0000;
        mcnt[i] = 8'd0;
        chk($sformatf("rst_valid[%0d]", i), {31'd0, act_v[i]}, 32'd0);
        chk($sformatf("rst_data[%0d]", i), {16'd0, act_d[i]}, 32'd0);
        chk($sformatf("rst_cnt[%0d]", i), {24'd0, act_c[i]}, 32'd0);
      end
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    end else begin
      logic exp_rdy;
      logic [3:0] exp_v;
      for (int i = 0; i < 4; i++) begin
        exp_v[i] = (sbq[i].size() != 0);
        chk($sformatf("valid[%0d]", i), {31'd0, act_v[i]}, {31'd0, exp_v[i]});
        chk($sformatf("data[%0d]", i), {16'd0, act_d[i]}, {16'd0, last_data[i]});
        if (exp_v[i])
          chk($sformatf("sb_data[%0d]", i), {16'd0, act_d[i]}, {16'd0, sbq[i][0]});
        chk($sformatf("cnt[%0d]", i), {24'd0, act_c[i]}, {24'd0, mcnt[i]});
      end
      exp_rdy = (sbq[in_sel].size() == 0) || rdy[in_sel];
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      for (int i = 0; i < 4; i++) begin
        if (exp_v[i] && rdy[i]) begin
          void'(sbq[i].pop_front());
          mcnt[i] = mcnt[i] + 8'd1;
        end
      end
      if (in_valid && exp_rdy) begin
        sbq[in_sel].push_back(in_data);
        last_data[in_sel] = in_data;
      end
    end
  end

  task automatic send(input logic [1:0] sel, input logic [WIDTH-1:0] data);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: sel %0d data 0x%0h never accepted, expected acceptance", sel, data);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  bit rnd_on;

  initial begin
    idle(2);
    rst_n = 1'b1;
    // Reset then idle with every select value
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      idle(1);
    end

    // Consecutive words to all four channels
    send(2'd0, 16'h1111);
    send(2'd1, 16'h2222);
    send(2'd2, 16'h3333);
    send(2'd3, 16'h4444);
    idle(2);
    chk("cnt_a_after4", {24'd0, a_cnt}, 32'd1);
    chk("cnt_d_after4", {24'd0, d_cnt}, 32'd1);

    // Backpressure on b does not block a
    b_ready = 1'b0;
    send(2'd1, 16'hAAAA);
    in_valid = 1'b1; in_sel = 2'd1; in_data = 16'hBBBB;
    idle(2);
    chk("b_held", {16'd0, b_data}, 32'h0000AAAA);
    in_valid = 1'b0;
    send(2'd0, 16'hCCCC);
    chk("a_gets_cccc", {16'd0, a_data}, 32'h0000CCCC);
    fork
      send(2'd1, 16'hBBBB);
      begin idle(2); b_ready = 1'b1; end
    join
    idle(2);

    // Full channel d drained and reloaded in the same cycle
    d_ready = 1'b0;
    send(2'd3, 16'h1234);
    d_ready = 1'b1;
    send(2'd3, 16'h5A5A);
    chk("d_valid_kept", {31'd0, d_valid}, 32'd1);
    chk("d_data_new", {16'd0, d_data}, 32'h00005A5A);
    idle(2);

    // Counter wrap on channel c starting from reset
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    for (int k = 0; k < 255; k++) send(2'd2, 16'(k));
    idle(1);
    chk("c_cnt_255", {24'd0, c_cnt}, 32'd255);
    send(2'd2, 16'hFFFF);
    idle(1);
    chk("c_cnt_wrap", {24'd0, c_cnt}, 32'd0);

    // Randomized traffic with random consumer stalls
    rnd_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 400; k++) send(2'($urandom_range(0, 3)), 16'($urandom));
        rnd_on = 1'b0;
      end
      while (rnd_on) begin
        @(posedge clk);
        #1;
        {d_ready, c_ready, b_ready, a_ready} = 4'($urandom);
      end
    join
    {d_ready, c_ready, b_ready, a_ready} = 4'b1111;
    idle(3);

    // Asynchronous reset with held words on a and b
    a_ready = 1'b0; b_ready = 1'b0;
    send(2'd0, 16'h0A0A);
    send(2'd1, 16'h0B0B);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_a_valid", {31'd0, a_valid}, 32'd0);
    chk("async_b_valid", {31'd0, b_valid}, 32'd0);
    chk("async_b_data", {16'd0, b_data}, 32'd0);
    chk("async_a_cnt", {24'd0, a_cnt}, 32'd0);
    chk("async_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_ready = 1'b1; b_ready = 1'b1;
    send(2'd2, 16'h7777);
    chk("c_data_7777", {16'd0, c_data}, 32'h00007777);
    idle(1);
    chk("c_cnt_after_rst", {24'd0, c_cnt}, 32'd1);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
